// File: rtl/canny_frame_ctrl_if.sv
// FIFO-side signal bundle of the Canny frame controller.
// Groups the four FIFO handshakes: source FIFO -> pipeline input FIFO,
// and pipeline output FIFO -> sink FIFO. Both read sides are
// first-word-fall-through, so the data is valid whenever empty is low.
interface canny_frame_ctrl_if;

    // source FIFO (24-bit RGB pixels)
    logic        src_empty;
    logic [23:0] src_dout;
    logic        src_rd_en;

    // pipeline image input FIFO
    logic        img_full;
    logic        img_wr_en;
    logic [23:0] img_din;

    // pipeline output FIFO (8-bit edge pixels)
    logic        out_empty;
    logic [7:0]  out_dout;
    logic        out_rd_en;

    // downstream sink FIFO
    logic        sink_full;
    logic        sink_wr_en;
    logic [7:0]  sink_din;

    // controller side
    modport master (
        input  src_empty, src_dout, img_full, out_empty, out_dout, sink_full,
        output src_rd_en, img_wr_en, img_din, out_rd_en, sink_wr_en, sink_din
    );

    // FIFO / environment side
    modport slave (
        output src_empty, src_dout, img_full, out_empty, out_dout, sink_full,
        input  src_rd_en, img_wr_en, img_din, out_rd_en, sink_wr_en, sink_din
    );

endinterface

// File: rtl/canny_frame_ctrl.sv
// Frame-level sequencer for the Canny edge-detection pipeline.
// Admits exactly WIDTH*HEIGHT pixels per start command into the pipeline,
// drains exactly as many edge pixels to the sink, then pulses frame_done.
// This keeps successive frames from interleaving inside the line-buffered
// stages. Input and output move concurrently while the frame runs: the
// pipeline FIFOs are shallow and stalling the output would deadlock it.
// All FIFO enables are combinational from state, counters and flags, giving
// a zero-cycle handshake and one pixel per cycle on each side.
module canny_frame_ctrl #(
    parameter int  WIDTH  = 1280,
    parameter int  HEIGHT = 720,
    localparam int NPIX   = WIDTH * HEIGHT,
    localparam int CW     = $clog2(NPIX + 1)
) (
    input  logic                    clock,
    input  logic                    reset,       // asynchronous, active-low
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    frame_done,
    output logic [CW-1:0]           in_count,
    output logic [CW-1:0]           out_count,
    canny_frame_ctrl_if.master      fifo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
    localparam logic [CW-1:0] ZERO_C = CW'(0);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   in_cnt_q;
    logic [CW-1:0]   in_cnt_d;
    logic [CW-1:0]   out_cnt_q;
    logic [CW-1:0]   out_cnt_d;
    logic            busy_q;
    logic            busy_d;
    logic            done_q;
    logic            done_d;
    logic            in_xfer_s;
    logic            out_xfer_s;
    logic            run_s;
    logic            draining_s;

    // Qualify the input and output transfers; abort suppresses both.
    always_comb begin
        in_xfer_s  = 1'b0;
        out_xfer_s = 1'b0;
        run_s      = (state_q == ST_RUN);
        draining_s = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        if (abort) begin
            in_xfer_s  = 1'b0;
            out_xfer_s = 1'b0;
        end else begin
            // the counter limit keeps a frame from admitting the next frame's pixels
            in_xfer_s  = run_s && (in_cnt_q < NPIX_C)
                         && !fifo.src_empty && !fifo.img_full;
            out_xfer_s = draining_s && (out_cnt_q < NPIX_C)
                         && !fifo.out_empty && !fifo.sink_full;
        end
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        if (abort) begin
            state_d   = ST_IDLE;
            in_cnt_d  = ZERO_C;
            out_cnt_d = ZERO_C;
        end else begin
            if (in_xfer_s) begin
                in_cnt_d = in_cnt_q + ONE_C;
            end else begin
                in_cnt_d = in_cnt_q;
            end

            if (out_xfer_s) begin
                out_cnt_d = out_cnt_q + ONE_C;
            end else begin
                out_cnt_d = out_cnt_q;
            end

            case (state_q)
                ST_IDLE: begin
                    // counters keep the last frame's totals until a new frame starts
                    if (start) begin
                        state_d   = ST_RUN;
                        in_cnt_d  = ZERO_C;
                        out_cnt_d = ZERO_C;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // last input and last output on the same edge skip DRAIN
                    if ((in_cnt_d == NPIX_C) && (out_cnt_d == NPIX_C)) begin
                        state_d = ST_DONE;
                    end else if (in_cnt_d == NPIX_C) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (out_cnt_d == NPIX_C) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    // start is ignored here; a held start is taken in the following IDLE cycle
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    in_cnt_d  = ZERO_C;
                    out_cnt_d = ZERO_C;
                end
            endcase
        end

        // status flags are registered from the next state so they track state exactly
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= ZERO_C;
            out_cnt_q <= ZERO_C;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign in_count   = in_cnt_q;
    assign out_count  = out_cnt_q;

    assign fifo.src_rd_en  = in_xfer_s;
    assign fifo.img_wr_en  = in_xfer_s;
    assign fifo.img_din    = fifo.src_dout;
    assign fifo.out_rd_en  = out_xfer_s;
    assign fifo.sink_wr_en = out_xfer_s;
    assign fifo.sink_din   = fifo.out_dout;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Self-checking bench for canny_frame_ctrl with a 4x2 frame (8 pixels).
// The environment is a queue-based model: a source FIFO of random pixels,
// a pipeline that turns each pixel into one byte after a configurable
// latency (or combinationally when zero_lat is set), and a sink log.
// Expectations come from frame arithmetic and the order pixels were generated.
module tb_canny_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam logic [CW-1:0] NPIX_V = CW'(NPIX);

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic           busy;
    logic           frame_done;
    logic [CW-1:0]  in_count;
    logic [CW-1:0]  out_count;
    logic           img_full_r;
    logic           sink_full_r;

    int checks = 0;
    int errors = 0;

    canny_frame_ctrl_if fifo_if ();

    canny_frame_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .frame_done (frame_done),
        .in_count   (in_count),
        .out_count  (out_count),
        .fifo       (fifo_if)
    );

    always #5 clock = ~clock;

    // ---------------- environment model ----------------
    logic [23:0] src_q[$];
    logic [23:0] gen_hist[$];
    logic [7:0]  pipe_d[$];
    int          pipe_t[$];
    logic [7:0]  sink_log[$];
    int          cyc       = 0;
    int          n_pop     = 0;
    int          n_img     = 0;
    int          n_sink    = 0;
    int          gen_total = 0;
    int          add_total = 0;
    int          lat       = 2;
    bit          zero_lat  = 1'b0;
    logic        src_empty_m = 1'b1;
    logic [23:0] src_dout_m  = 24'd0;
    logic        pipe_vis_m  = 1'b0;
    logic [7:0]  pipe_head_m = 8'd0;

    function automatic logic [7:0] pix_to_out(input logic [23:0] p);
        return p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

    assign fifo_if.src_empty = src_empty_m;
    assign fifo_if.src_dout  = src_dout_m;
    assign fifo_if.img_full  = img_full_r;
    assign fifo_if.sink_full = sink_full_r;
    assign fifo_if.out_empty = !(pipe_vis_m || (zero_lat && fifo_if.img_wr_en));
    assign fifo_if.out_dout  = pipe_vis_m ? pipe_head_m : pix_to_out(fifo_if.img_din);

    // FIFO bookkeeping on each rising edge, flags refreshed just after it
    always @(posedge clock) begin
        logic        s_rd, i_wr, o_rd, k_wr;
        logic [23:0] i_din, px;
        logic [7:0]  k_din, b;
        int          t;
        s_rd  = fifo_if.src_rd_en;
        i_wr  = fifo_if.img_wr_en;
        i_din = fifo_if.img_din;
        o_rd  = fifo_if.out_rd_en;
        k_wr  = fifo_if.sink_wr_en;
        k_din = fifo_if.sink_din;
        cyc++;
        if (s_rd && src_q.size() > 0) begin px = src_q.pop_front(); n_pop++; end
        if (i_wr) begin pipe_d.push_back(pix_to_out(i_din)); pipe_t.push_back(cyc + lat); n_img++; end
        if (o_rd && pipe_d.size() > 0) begin b = pipe_d.pop_front(); t = pipe_t.pop_front(); end
        if (k_wr) begin sink_log.push_back(k_din); n_sink++; end
        if (!reset) begin pipe_d.delete(); pipe_t.delete(); end
        while (gen_total < add_total) begin
            px = 24'($urandom);
            src_q.push_back(px);
            gen_hist.push_back(px);
            gen_total++;
        end
        #1;
        src_empty_m = (src_q.size() == 0);
        src_dout_m  = (src_q.size() > 0) ? src_q[0] : 24'd0;
        pipe_vis_m  = (pipe_d.size() > 0) && (pipe_t[0] <= cyc);
        pipe_head_m = pipe_vis_m ? pipe_d[0] : 8'd0;
    end

    // ---------------- frame runner (stimulus + observation only) ----------------
    task automatic run_frame(input int budget, output int n_done, output int done_at,
                             output int fall_at, output int rd_late, output bit timeout);
        start = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        n_done  = 0; done_at = -1; fall_at = -1; rd_late = 0; timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (frame_done === 1'b1) begin n_done++; done_at = i; end
            if (in_count == NPIX_V && fifo_if.src_rd_en === 1'b1) rd_late++;
            if (busy !== 1'b1) begin fall_at = i; timeout = 1'b0; break; end
            @(negedge clock);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        img_full_r = 1'b0; sink_full_r = 1'b0;
        add_total += NPIX;           // these 8 pixels feed the nominal frame
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", frame_done); end
        checks++; if (in_count !== CW'(0)) begin errors++; $display("FAIL reset_in_count got %0d exp 0", in_count); end
        checks++; if (out_count !== CW'(0)) begin errors++; $display("FAIL reset_out_count got %0d exp 0", out_count); end
        checks++; if ({fifo_if.src_rd_en, fifo_if.img_wr_en, fifo_if.out_rd_en, fifo_if.sink_wr_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_enables got %b exp 0000",
                {fifo_if.src_rd_en, fifo_if.img_wr_en, fifo_if.out_rd_en, fifo_if.sink_wr_en}); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (fifo_if.src_rd_en !== 1'b0) begin errors++; $display("FAIL idle_no_pop got %0b exp 0 (src has data)", fifo_if.src_rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", busy); end
    endtask

    task automatic test_nominal;
        int nd, da, fa, rl, p0, i0, s0;
        bit to;
        lat = 3;
        p0 = n_pop; i0 = n_img; s0 = n_sink;
        run_frame(80, nd, da, fa, rl, to);
        checks++; if (to) begin errors++; $display("FAIL nom_timeout got busy stuck exp fall"); end
        checks++; if (nd != 1) begin errors++; $display("FAIL nom_done_pulses got %0d exp 1", nd); end
        checks++; if (n_img - i0 != NPIX) begin errors++; $display("FAIL nom_img_writes got %0d exp %0d", n_img - i0, NPIX); end
        checks++; if (n_sink - s0 != NPIX) begin errors++; $display("FAIL nom_sink_writes got %0d exp %0d", n_sink - s0, NPIX); end
        checks++; if (in_count !== NPIX_V) begin errors++; $display("FAIL nom_in_count got %0d exp %0d", in_count, NPIX); end
        checks++; if (out_count !== NPIX_V) begin errors++; $display("FAIL nom_out_count got %0d exp %0d", out_count, NPIX); end
        checks++; if (fa != da + 1) begin errors++; $display("FAIL nom_busy_fall got %0d exp %0d", fa, da + 1); end
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (s0 + k >= sink_log.size() || sink_log[s0 + k] !== pix_to_out(gen_hist[p0 + k])) begin
                errors++; $display("FAIL nom_order[%0d] got %0h exp %0h", k,
                    (s0 + k < sink_log.size()) ? sink_log[s0 + k] : 8'hxx, pix_to_out(gen_hist[p0 + k]));
            end
        end
        repeat (3) @(negedge clock);
        checks++; if (in_count !== NPIX_V || out_count !== NPIX_V) begin
            errors++; $display("FAIL nom_counts_hold got %0d/%0d exp %0d/%0d", in_count, out_count, NPIX, NPIX); end
    endtask

    task automatic test_frame_boundary;
        int nd, da, fa, rl, p0, s0;
        bit to;
        lat = 2;
        add_total += 12;
        repeat (2) @(negedge clock);
        p0 = n_pop;
        run_frame(80, nd, da, fa, rl, to);
        checks++; if (to || nd != 1) begin errors++; $display("FAIL fb1_done got %0d timeout %0b exp 1", nd, to); end
        checks++; if (n_pop - p0 != NPIX) begin errors++; $display("FAIL fb1_pops got %0d exp %0d", n_pop - p0, NPIX); end
        checks++; if (src_q.size() != 4) begin errors++; $display("FAIL fb1_left got %0d exp 4", src_q.size()); end
        checks++; if (rl != 0) begin errors++; $display("FAIL fb1_pop_in_drain got %0d exp 0", rl); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (fifo_if.src_rd_en !== 1'b0) begin errors++; $display("FAIL fb_idle_pop got %0b exp 0", fifo_if.src_rd_en); end
            @(negedge clock);
        end
        add_total += 4;
        repeat (2) @(negedge clock);
        p0 = n_pop; s0 = n_sink;
        run_frame(80, nd, da, fa, rl, to);
        checks++; if (to || nd != 1) begin errors++; $display("FAIL fb2_done got %0d timeout %0b exp 1", nd, to); end
        checks++; if (n_pop - p0 != NPIX || src_q.size() != 0) begin
            errors++; $display("FAIL fb2_pops got %0d left %0d exp %0d left 0", n_pop - p0, src_q.size(), NPIX); end
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (s0 + k >= sink_log.size() || sink_log[s0 + k] !== pix_to_out(gen_hist[p0 + k])) begin
                errors++; $display("FAIL fb2_order[%0d] exp %0h", k, pix_to_out(gen_hist[p0 + k])); end
        end
    endtask

    task automatic test_back_pressure;
        int p0, s0, nd, early;
        bit to;
        lat = 2;
        add_total += NPIX;
        repeat (2) @(negedge clock);
        p0 = n_pop; s0 = n_sink; nd = 0; early = 0; to = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            checks++; if (in_count !== CW'(n_pop - p0)) begin
                errors++; $display("FAIL bp_in_count got %0d exp %0d", in_count, n_pop - p0); end
            checks++; if (out_count !== CW'(n_sink - s0)) begin
                errors++; $display("FAIL bp_out_count got %0d exp %0d", out_count, n_sink - s0); end
            checks++; if ((fifo_if.img_wr_en & img_full_r) !== 1'b0 || (fifo_if.sink_wr_en & sink_full_r) !== 1'b0) begin
                errors++; $display("FAIL bp_write_when_full img %0b sink %0b exp 0 0",
                    fifo_if.img_wr_en & img_full_r, fifo_if.sink_wr_en & sink_full_r); end
            if (frame_done === 1'b1) begin
                nd++;
                if (n_sink - s0 != NPIX) early++;
            end
            if (busy !== 1'b1) begin to = 1'b0; break; end
            img_full_r  = 1'($urandom_range(0, 1));
            sink_full_r = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        img_full_r = 1'b0; sink_full_r = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got busy stuck exp fall"); end
        checks++; if (nd != 1 || early != 0) begin errors++; $display("FAIL bp_done got %0d early %0d exp 1 early 0", nd, early); end
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (s0 + k >= sink_log.size() || sink_log[s0 + k] !== pix_to_out(gen_hist[p0 + k])) begin
                errors++; $display("FAIL bp_order[%0d] exp %0h", k, pix_to_out(gen_hist[p0 + k])); end
        end
    endtask

    task automatic test_simultaneous;
        bit seen;
        logic fd;
        logic [CW-1:0] oc;
        zero_lat = 1'b1; lat = 0;
        add_total += NPIX;
        repeat (2) @(negedge clock);
        seen = 1'b0; fd = 1'b0; oc = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_count == NPIX_V) begin seen = 1'b1; fd = frame_done; oc = out_count; break; end
            @(negedge clock);
        end
        checks++; if (!seen) begin errors++; $display("FAIL sim_timeout got in_count %0d exp %0d", in_count, NPIX); end
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL sim_direct_done got %0b exp 1", fd); end
        checks++; if (oc !== NPIX_V) begin errors++; $display("FAIL sim_out_count got %0d exp %0d", oc, NPIX); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL sim_after got busy %0b done %0b exp 0 0", busy, frame_done); end
        zero_lat = 1'b0; lat = 2;
    endtask

    task automatic test_abort;
        int pa, bad;
        bit seen;
        lat = 2;
        add_total += NPIX;
        repeat (2) @(negedge clock);
        seen = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_count == CW'(5)) begin seen = 1'b1; break; end
            @(negedge clock);
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_reach5 got %0d exp 5", in_count); end
        abort = 1'b1;
        #1;
        checks++; if ({fifo_if.src_rd_en, fifo_if.img_wr_en, fifo_if.out_rd_en, fifo_if.sink_wr_en} !== 4'b0000) begin
            errors++; $display("FAIL abort_cycle_xfer got %b exp 0000",
                {fifo_if.src_rd_en, fifo_if.img_wr_en, fifo_if.out_rd_en, fifo_if.sink_wr_en}); end
        pa = n_pop;
        @(negedge clock);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL abort_state got busy %0b done %0b exp 0 0", busy, frame_done); end
        checks++; if (in_count !== CW'(0) || out_count !== CW'(0)) begin
            errors++; $display("FAIL abort_counts got %0d/%0d exp 0/0", in_count, out_count); end
        checks++; if (n_pop != pa || fifo_if.src_rd_en !== 1'b0) begin
            errors++; $display("FAIL abort_pops got %0d extra rd %0b exp 0 0", n_pop - pa, fifo_if.src_rd_en); end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad); end
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || in_count !== CW'(0)) begin
            errors++; $display("FAIL abort_priority got busy %0b in %0d exp 0 0", busy, in_count); end
    endtask

    task automatic test_async_reset;
        int nd, da, fa, rl, p0, s0, bad;
        bit to, seen;
        // flush what the aborted frame left in the pipeline
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        lat = 4;
        add_total += NPIX - src_q.size();
        repeat (2) @(negedge clock);
        seen = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_count == NPIX_V && out_count < NPIX_V && busy === 1'b1) begin seen = 1'b1; break; end
            @(negedge clock);
        end
        checks++; if (!seen) begin errors++; $display("FAIL ar_reach_drain got %0d/%0d exp 8/<8", in_count, out_count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL ar_status got busy %0b done %0b exp 0 0", busy, frame_done); end
        checks++; if (in_count !== CW'(0) || out_count !== CW'(0)) begin
            errors++; $display("FAIL ar_counts got %0d/%0d exp 0/0", in_count, out_count); end
        checks++; if ({fifo_if.src_rd_en, fifo_if.img_wr_en, fifo_if.out_rd_en, fifo_if.sink_wr_en} !== 4'b0000) begin
            errors++; $display("FAIL ar_enables got %b exp 0000",
                {fifo_if.src_rd_en, fifo_if.img_wr_en, fifo_if.out_rd_en, fifo_if.sink_wr_en}); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ar_no_partial_done got %0d exp 0", bad); end
        add_total += NPIX;
        repeat (2) @(negedge clock);
        p0 = n_pop; s0 = n_sink;
        run_frame(80, nd, da, fa, rl, to);
        checks++; if (to || nd != 1 || in_count !== NPIX_V || out_count !== NPIX_V) begin
            errors++; $display("FAIL ar_clean_frame got done %0d counts %0d/%0d exp 1 8/8", nd, in_count, out_count); end
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (s0 + k >= sink_log.size() || sink_log[s0 + k] !== pix_to_out(gen_hist[p0 + k])) begin
                errors++; $display("FAIL ar_order[%0d] exp %0h", k, pix_to_out(gen_hist[p0 + k])); end
        end
    endtask

    task automatic test_back_to_back;
        int p0, s0, nd;
        bit to;
        lat = 1;
        add_total += 2 * NPIX;
        repeat (2) @(negedge clock);
        p0 = n_pop; s0 = n_sink; nd = 0; to = 1'b1;
        start = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 200; i++) begin
            if (frame_done === 1'b1) begin
                nd++;
                if (nd == 1) begin
                    @(negedge clock);
                    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap got busy %0b exp 0", busy); end
                    @(negedge clock);
                    checks++; if (busy !== 1'b1 || in_count !== CW'(0)) begin
                        errors++; $display("FAIL b2b_restart got busy %0b in %0d exp 1 0", busy, in_count); end
                    start = 1'b0;
                end
            end
            if (nd == 2 && busy !== 1'b1) begin to = 1'b0; break; end
            @(negedge clock);
        end
        start = 1'b0;
        checks++; if (to || nd != 2) begin errors++; $display("FAIL b2b_frames got %0d timeout %0b exp 2", nd, to); end
        checks++; if (n_pop - p0 != 2 * NPIX || n_sink - s0 != 2 * NPIX) begin
            errors++; $display("FAIL b2b_xfers got %0d/%0d exp %0d", n_pop - p0, n_sink - s0, 2 * NPIX); end
        for (int k = 0; k < 2 * NPIX; k++) begin
            checks++;
            if (s0 + k >= sink_log.size() || sink_log[s0 + k] !== pix_to_out(gen_hist[p0 + k])) begin
                errors++; $display("FAIL b2b_order[%0d] exp %0h", k, pix_to_out(gen_hist[p0 + k])); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_frame_boundary();
        test_back_pressure();
        test_simultaneous();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/canny_frame_ctrl.md
# canny_frame_ctrl

Frame-level sequencer for the Canny edge-detection pipeline. Sits between a 24-bit RGB pixel source FIFO and the pipeline's image input FIFO, and between the pipeline's 8-bit output FIFO and a downstream sink FIFO. Admits exactly one frame (WIDTH×HEIGHT pixels) per `start` command, drains exactly as many output pixels, then pulses `frame_done`. This keeps successive frames from interleaving inside the line-buffered stages.

## Interface
- `WIDTH`, 1280, pixels per line
- `HEIGHT`, 720, lines per frame
- Derived: `NPIX = WIDTH*HEIGHT`; `CW = $clog2(NPIX+1)` (20 at defaults)

- `clock`  in  1  sole clock; all state is on the rising edge
- `reset`  in  1  asynchronous, active-low; one clock domain
- `start`  in  1  frame request; sampled only in IDLE
- `abort`  in  1  synchronous; returns the block to IDLE and clears the counters
- `busy`  out  1  high in RUN, DRAIN and DONE
- `frame_done`  out  1  one-cycle pulse in DONE
- `src_empty`  in  1  source FIFO empty
- `src_dout`  in  24  source FIFO data, first-word-fall-through
- `src_rd_en`  out  1  source pop
- `img_full`  in  1  pipeline input FIFO full
- `img_wr_en`  out  1  pipeline input push
- `img_din`  out  24  equals `src_dout`
- `out_empty`  in  1  pipeline output FIFO empty
- `out_dout`  in  8  pipeline output data, first-word-fall-through
- `out_rd_en`  out  1  pipeline output pop
- `sink_full`  in  1  sink FIFO full
- `sink_wr_en`  out  1  sink push
- `sink_din`  out  8  equals `out_dout`
- `in_count`  out  CW  pixels admitted in the current frame
- `out_count`  out  CW  pixels drained in the current frame

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. Encoding is free.
- **IDLE:**
  - `start`=1 and `abort`=0 → RUN, and both counters clear to 0.
  - No transfers occur in IDLE.
- **Input transfer:** `in_xfer = (state==RUN) & (in_count<NPIX) & !src_empty & !img_full`.
  - `src_rd_en = img_wr_en = in_xfer`.
  - `in_count` increments on each transfer.
- **Output transfer:** `out_xfer = (state∈{RUN,DRAIN}) & (out_count<NPIX) & !out_empty & !sink_full`.
  - `out_rd_en = sink_wr_en = out_xfer`.
  - `out_count` increments on each transfer.
  - Output drains concurrently with input during RUN. This is mandatory: the pipeline FIFOs are small, and holding output off would deadlock the pipeline.
- **RUN → DRAIN:** on the edge where `in_count` becomes NPIX.
- **DRAIN → DONE:** on the edge where `out_count` becomes NPIX.
- **Direct RUN → DONE:** if the final input and final output transfers land on the same edge, the block goes straight to DONE.
- **DONE:** lasts one cycle with `frame_done`=1, then → IDLE. `start` is ignored during DONE.
- **Counters** hold their final values (NPIX) in IDLE until the next accepted `start`. They never exceed NPIX and never wrap.
- **Pixel count contract:** the pipeline emits exactly one output pixel per input pixel, so NPIX out per frame.
- **abort:**
  - From any state → IDLE next edge; counters clear to 0; no `frame_done`.
  - Transfers are suppressed in the `abort` cycle.
  - `abort` has priority over `start`.
  - Flushing pipeline FIFO contents is the system's job, via `reset`.

## Timing
- All enables and data pass-throughs are combinational from the current state, counters and FIFO flags, so there is zero-cycle handshake latency. The block sustains one input and one output pixel per cycle simultaneously.
- **Reset values (while `reset`=0):**
  - state=IDLE
  - `in_count`=`out_count`=0
  - `busy`=`frame_done`=0
  - all `*_rd_en`/`*_wr_en`=0
- `busy` is registered by state. It rises the cycle after `start` is accepted and falls the cycle after DONE.
- `frame_done` is high exactly one cycle, namely the cycle after the edge on which `out_count` reached NPIX.
- **Back-pressure:** with `img_full`=1 or `src_empty`=1, `in_count` holds. With `sink_full`=1 or `out_empty`=1, `out_count` holds. The state is unchanged in both cases.
- **Asynchronous reset mid-frame:** all outputs are forced to their reset values immediately, and no partial `frame_done` is produced.
- **Back-to-back frames:** `start` held high re-enters RUN on the cycle after DONE, giving one idle cycle between frames.

## Test plan
Bench uses WIDTH=4, HEIGHT=2 (NPIX=8); the pipeline is modelled as a FIFO passthrough with latency.
- **Nominal frame:** 8 source pixels queued, `start` for 1 cycle → 8 `img_wr_en` pulses, 8 `sink_wr_en` pulses, a single `frame_done` pulse, `in_count`=`out_count`=8, and `busy` falling one cycle after `frame_done`.
- **Frame boundary:** 12 source pixels queued → only 8 popped; 4 remain and `src_rd_en` stays 0 in DRAIN and IDLE. A second `start` → the remaining 4 plus 4 more are admitted.
- **Back-pressure:** toggle `img_full` and `sink_full` randomly at 50% → the counts never skip or double, the data order at the sink matches the source order, and `frame_done` occurs only after the 8th sink write.
- **Simultaneous last transfers:** zero-latency pipeline model so the 8th input and 8th output land on the same edge → RUN→DONE directly and `frame_done` the next cycle.
- **Abort:** `abort` asserted at `in_count`=5 → next cycle IDLE with counts 0, no `frame_done`, and no enables. `start`+`abort` asserted together in IDLE → the block stays IDLE.
- **Asynchronous reset:** `reset` low mid-DRAIN between clock edges → outputs 0 immediately. After release, `start` runs a clean frame.
